// File: rtl/muldiv_seq.sv
// Iterative 32-bit multiply/divide unit: radix-2 shift-add multiply, restoring divide, 33-cycle latency.
// Optional macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle 64-bit multiplier.
module muldiv_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [4:0]            op_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] res_o
);

    localparam int W = DATA_WIDTH;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [5:0] LAST_STEP = 6'(W - 1);
    localparam logic [W-1:0]   ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [2*W-1:0] ONE_WIDE = {{(2*W-1){1'b0}}, 1'b1};

    function automatic logic a_signed_f(input logic [2:0] f);
        case (f)
            3'd1, 3'd2, 3'd4, 3'd6: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic b_signed_f(input logic [2:0] f);
        case (f)
            3'd1, 3'd4, 3'd6: return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic en);
        return en ? (~v + ONE_W) : v;
    endfunction

    // Final sign correction and selection from the magnitude product or quotient/remainder.
    function automatic logic [W-1:0] result_f(input logic [4:0] op, input logic sa, input logic sb,
                                              input logic b_zero, input logic [W-1:0] hi,
                                              input logic [W-1:0] lo);
        logic [2*W-1:0] prod;
        prod = {hi, lo};
        if (op[4:3] != 2'b10) begin
            return {W{1'b0}};
        end else if (!op[2]) begin
            prod = (sa ^ sb) ? (~prod + ONE_WIDE) : prod;
            return (op[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        end else if (!op[1]) begin
            return b_zero ? {W{1'b1}} : neg_w(lo, sa ^ sb);
        end else begin
            // Divide-by-zero leaves |a| in the remainder, so re-signing restores a_i.
            return neg_w(hi, sa);
        end
    endfunction

    logic [1:0]   state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [4:0]   op_q, op_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic         sa_q, sa_d, sb_q, sb_d;
    logic [W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [W-1:0] res_q, res_d;
    logic         valid_q, valid_d, ready_q, ready_d;

    logic         a_neg_s, b_neg_s;
    logic [W-1:0] a_mag_s, b_mag_s;
    logic [W:0]   mul_sum_s, div_shift_s, div_diff_s;
    logic [W-1:0] step_hi_s, step_lo_s;
    logic         b_zero_s;

    assign a_neg_s  = a_i[W-1] & a_signed_f(op_i[2:0]);
    assign b_neg_s  = b_i[W-1] & b_signed_f(op_i[2:0]);
    assign a_mag_s  = neg_w(a_i, a_neg_s);
    assign b_mag_s  = neg_w(b_i, b_neg_s);
    assign b_zero_s = (b_q == {W{1'b0}});

`ifdef MULDIV_FAST_MUL_EN
    logic [2*W-1:0] fast_prod_s;
    logic [W-1:0]   fast_res_s;
    assign fast_prod_s = {{W{1'b0}}, a_mag_s} * {{W{1'b0}}, b_mag_s};
    assign fast_res_s  = result_f(op_i, a_neg_s, b_neg_s, 1'b0, fast_prod_s[2*W-1:W],
                                  fast_prod_s[W-1:0]);
`endif

    // One radix-2 step: {hi,lo} is the product accumulator or the remainder/quotient pair.
    always_comb begin
        mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
        div_shift_s = {hi_q, lo_q[W-1]};
        div_diff_s  = div_shift_s - {1'b0, b_q};
        if (!op_q[2]) begin
            step_hi_s = mul_sum_s[W:1];
            step_lo_s = {mul_sum_s[0], lo_q[W-1:1]};
        end else if (!div_diff_s[W]) begin
            step_hi_s = div_diff_s[W-1:0];
            step_lo_s = {lo_q[W-2:0], 1'b1};
        end else begin
            step_hi_s = div_shift_s[W-1:0];
            step_lo_s = {lo_q[W-2:0], 1'b0};
        end
    end

    // Next-state logic; flush overrides everything else.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = 6'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        op_d    = op_i;
                        a_d     = a_mag_s;
                        b_d     = b_mag_s;
                        sa_d    = a_neg_s;
                        sb_d    = b_neg_s;
                        cnt_d   = 6'd0;
                        hi_d    = {W{1'b0}};
                        lo_d    = op_i[2] ? a_mag_s : b_mag_s;
                        state_d = S_CALC;
`ifdef MULDIV_FAST_MUL_EN
                        if (op_i[4:2] == 3'b100) begin
                            state_d = S_DONE;
                            res_d   = fast_res_s;
                        end else begin
                            state_d = S_CALC;
                        end
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    hi_d  = step_hi_s;
                    lo_d  = step_lo_s;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_STEP) begin
                        state_d = S_DONE;
                        res_d   = result_f(op_q, sa_q, sb_q, b_zero_s, step_hi_s, step_lo_s);
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
        valid_d = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            op_q    <= 5'd0;
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= {W{1'b0}};
            lo_q    <= {W{1'b0}};
            res_q   <= {W{1'b0}};
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign res_o   = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed corner cases, flush/reset aborts, randomized ops vs reference model.
module tb_muldiv_seq;

    localparam logic [4:0] OP_MUL = 5'b10000, OP_MULH = 5'b10001, OP_MULHSU = 5'b10010,
                           OP_MULHU = 5'b10011, OP_DIV = 5'b10100, OP_DIVU = 5'b10101,
                           OP_REM = 5'b10110, OP_REMU = 5'b10111;

    logic        clk = 1'b0;
    logic        rst, valid_i, ready_o, flush_i, valid_o;
    logic [31:0] a_i, b_i, res_o;
    logic [4:0]  op_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  op;
        int          acc;
        int          lat;
    } exp_t;
    exp_t sb_q[$];

    muldiv_seq #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .op_i(op_i), .flush_i(flush_i),
        .valid_o(valid_o), .res_o(res_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic with the architectural corner cases.
    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        sa = a;
        sb = b;
        if (op[4:3] != 2'b10) return 32'h0;
        case (op[2:0])
            3'd0: begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'h0, b}; return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] op);
`ifdef MULDIV_FAST_MUL_EN
        if (op[4:2] == 3'b100) return 1;
`endif
        return 33;
    endfunction

    // Monitor: every valid_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got res 0x%08h expected no result", res_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("result op=%b", e.op), res_o, e.res);
                check($sformatf("latency op=%b", e.op), 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        int guard = 0;
        @(negedge clk);
        while (ready_o !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: got ready_o %b expected 1", ready_o);
                return;
            end
        end
        op_i = op; a_i = a; b_i = b; valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        sb_q.push_back('{res: exp, op: op, acc: cyc, lat: ref_lat(op)});
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; a_i = 32'h0; b_i = 32'h0; op_i = 5'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'h0, ready_o}, 32'h1);
        check("reset_valid", {31'h0, valid_o}, 32'h0);
        check("reset_res", res_o, 32'h0);

        issue(OP_MUL,    32'd7,          32'd6,          32'h0000_002A);
        issue(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000);
        issue(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE);
        issue(OP_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF);
        issue(OP_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
        issue(OP_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
        issue(OP_DIVU,   32'd100,        32'd7,          32'd14);
        issue(OP_REMU,   32'd100,        32'd7,          32'd2);
        issue(OP_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF);
        issue(OP_REM,    32'd5,          32'd0,          32'd5);
        issue(OP_DIV,    32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF);
        issue(OP_REM,    32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB);
        issue(OP_DIVU,   32'd5,          32'd0,          32'hFFFF_FFFF);
        issue(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
        issue(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000);
        issue(5'b01000,  32'd9,          32'd3,          32'h0000_0000);
        drain();

        // Flush mid-divide: no result, immediately ready, next op at normal latency.
        issue(OP_DIV, 32'd1000, 32'd3, 32'd333);
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("flush_ready", {31'h0, ready_o}, 32'h1);
        check("flush_valid", {31'h0, valid_o}, 32'h0);
        issue(OP_MUL, 32'd3, 32'd3, 32'd9);
        drain();

        // Reset mid-CALC while valid_i is held: busy throughout, then discarded.
        issue(OP_DIV, 32'd1234, 32'd5, 32'd246);
        @(negedge clk);
        op_i = OP_MUL; a_i = 32'd2; b_i = 32'd2; valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("busy_ready", {31'h0, ready_o}, 32'h0);
        end
        rst = 1'b1;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        sb_q.delete();
        @(negedge clk);
        check("midreset_valid", {31'h0, valid_o}, 32'h0);
        check("midreset_res", res_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("postreset_ready", {31'h0, ready_o}, 32'h1);
        repeat (40) @(negedge clk);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                rop = 5'($urandom_range(0, 31));
                if (rop[4:3] == 2'b10) rop[4:3] = 2'b11;
            end else begin
                rop = {2'b10, 3'($urandom_range(0, 7))};
            end
            ra = pick();
            rb = pick();
            issue(rop, ra, rb, ref_model(rop, ra, rb));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
